// File: rtl/dpram_port_a_arbiter_if.sv
// rtl/dpram_port_a_arbiter_if.sv - requester, RAM port A and port B monitor bundle for the port A arbiter
interface dpram_port_a_arbiter_if #(
  parameter int N   = 4,
  parameter int AW  = 4,
  parameter int DW  = 8,
  parameter int IDW = 2
);
  logic [N-1:0]    req;
  logic [N-1:0]    req_we;
  logic [N*AW-1:0] req_addr;
  logic [N*DW-1:0] req_din;
  logic [N-1:0]    gnt;
  logic [DW-1:0]   rdata;
  logic            rvalid;
  logic [IDW-1:0]  rid;
  logic            ram_we_a;
  logic [AW-1:0]   ram_addr_a;
  logic [DW-1:0]   ram_din_a;
  logic [DW-1:0]   ram_dout_a;
  logic            mon_we_b;
  logic [AW-1:0]   mon_addr_b;
  logic            collision;
  logic            clr_collision;
  logic            busy;

  modport slave (
    input  req, req_we, req_addr, req_din, ram_dout_a, mon_we_b, mon_addr_b, clr_collision,
    output gnt, rdata, rvalid, rid, ram_we_a, ram_addr_a, ram_din_a, collision, busy
  );

  modport master (
    output req, req_we, req_addr, req_din, ram_dout_a, mon_we_b, mon_addr_b, clr_collision,
    input  gnt, rdata, rvalid, rid, ram_we_a, ram_addr_a, ram_din_a, collision, busy
  );
endinterface

// File: rtl/dpram_port_a_arbiter.sv
// rtl/dpram_port_a_arbiter.sv - round-robin sequencer sharing RAM port A between N requesters
module dpram_port_a_arbiter #(
  parameter int N      = 4,
  parameter int AW     = 4,
  parameter int DW     = 8,
  parameter int RD_LAT = 1,
  parameter int IDW    = 2
) (
  input  logic                 clk,
  input  logic                 rst,
  dpram_port_a_arbiter_if.slave bus
);

  typedef enum logic [1:0] {IDLE, ISSUE, WAIT, RESP} state_t;

  state_t         state_q;
  logic [IDW-1:0] ptr_q;
  logic [IDW-1:0] win_q;
  logic [IDW-1:0] win_d;
  logic           found_d;
  logic [IDW:0]   idx;
  logic [1:0]     cnt_q;
  logic [N-1:0]   gnt_q;
  logic [DW-1:0]  rdata_q;
  logic           rvalid_q;
  logic [IDW-1:0] rid_q;
  logic           we_q;
  logic [AW-1:0]  addr_q;
  logic [DW-1:0]  din_q;
  logic           coll_q;
  logic           busy_q;

  // First requesting index at or above ptr, wrapping modulo N.
  always_comb begin
    found_d = 1'b0;
    win_d   = '0;
    idx     = '0;
    for (int k = 0; k < N; k++) begin
      idx = {1'b0, ptr_q} + (IDW+1)'(k);
      if (idx >= (IDW+1)'(N)) idx = idx - (IDW+1)'(N);
      if (!found_d && bus.req[idx[IDW-1:0]]) begin
        found_d = 1'b1;
        win_d   = idx[IDW-1:0];
      end
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q  <= IDLE;
      ptr_q    <= '0;
      win_q    <= '0;
      cnt_q    <= '0;
      gnt_q    <= '0;
      rdata_q  <= '0;
      rvalid_q <= 1'b0;
      rid_q    <= '0;
      we_q     <= 1'b0;
      addr_q   <= '0;
      din_q    <= '0;
      coll_q   <= 1'b0;
      busy_q   <= 1'b0;
    end else begin
      rvalid_q <= 1'b0;
      case (state_q)
        IDLE: begin
          we_q <= 1'b0;
          if (found_d) begin
            win_q   <= win_d;
            addr_q  <= bus.req_addr[win_d*AW +: AW];
            din_q   <= bus.req_din[win_d*DW +: DW];
            we_q    <= bus.req_we[win_d];
            gnt_q   <= N'(1) << win_d;
            busy_q  <= 1'b1;
            state_q <= ISSUE;
          end
        end
        ISSUE: begin
          gnt_q <= '0;
          we_q  <= 1'b0;
          ptr_q <= (win_q == IDW'(N-1)) ? '0 : win_q + 1'b1;
          if (we_q) begin
            busy_q  <= 1'b0;
            state_q <= IDLE;
          end else if (RD_LAT == 1) begin
            state_q <= RESP;
          end else begin
            cnt_q   <= 2'(RD_LAT-1);
            state_q <= WAIT;
          end
        end
        WAIT: begin
          if (cnt_q == 2'd1) state_q <= RESP;
          else               cnt_q   <= cnt_q - 1'b1;
        end
        RESP: begin
          rdata_q  <= bus.ram_dout_a;
          rid_q    <= win_q;
          rvalid_q <= 1'b1;
          busy_q   <= 1'b0;
          state_q  <= IDLE;
        end
        default: state_q <= IDLE;
      endcase

      // Only a same-cycle write on both ports counts; set beats clear.
      if (state_q == ISSUE && we_q && bus.mon_we_b && addr_q == bus.mon_addr_b)
        coll_q <= 1'b1;
      else if (bus.clr_collision)
        coll_q <= 1'b0;
    end
  end

  assign bus.gnt        = gnt_q;
  assign bus.rdata      = rdata_q;
  assign bus.rvalid     = rvalid_q;
  assign bus.rid        = rid_q;
  assign bus.ram_we_a   = we_q;
  assign bus.ram_addr_a = addr_q;
  assign bus.ram_din_a  = din_q;
  assign bus.collision  = coll_q;
  assign bus.busy       = busy_q;

endmodule

// File: tb/tb_dpram_port_a_arbiter.sv
// tb/tb_dpram_port_a_arbiter.sv - directed bench for the port A arbiter at RD_LAT 1 and 3
module tb_dpram_port_a_arbiter;

  logic clk = 1'b0;
  logic rst = 1'b1;
  int   total = 0;
  int   bad   = 0;

  always #5 clk = ~clk;

  dpram_port_a_arbiter_if #(.N(4), .AW(4), .DW(8), .IDW(2)) if1 ();
  dpram_port_a_arbiter_if #(.N(4), .AW(4), .DW(8), .IDW(2)) if3 ();

  dpram_port_a_arbiter #(.N(4), .AW(4), .DW(8), .RD_LAT(1), .IDW(2)) u1 (.clk(clk), .rst(rst), .bus(if1.slave));
  dpram_port_a_arbiter #(.N(4), .AW(4), .DW(8), .RD_LAT(3), .IDW(2)) u3 (.clk(clk), .rst(rst), .bus(if3.slave));

  logic [7:0] mem1 [16] = '{8'h30, 8'h31, 8'h32, 8'h33, 8'h34, 8'h35, 8'h36, 8'h37,
                            8'h38, 8'h39, 8'h3A, 8'h3B, 8'h3C, 8'h3D, 8'h3E, 8'h3F};
  logic [7:0] mem3 [16] = '{8'h30, 8'h31, 8'h32, 8'h33, 8'h34, 8'h35, 8'h36, 8'h37,
                            8'h38, 8'h39, 8'h3A, 8'h3B, 8'h3C, 8'h3D, 8'h3E, 8'h3F};
  logic [7:0] p0, p1;

  always @(posedge clk) begin
    if (if1.ram_we_a) mem1[if1.ram_addr_a] <= if1.ram_din_a;
    if1.ram_dout_a <= mem1[if1.ram_addr_a];
    if (if3.ram_we_a) mem3[if3.ram_addr_a] <= if3.ram_din_a;
    p0 <= mem3[if3.ram_addr_a];
    p1 <= p0;
    if3.ram_dout_a <= p1;
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  initial begin
    if1.req = '0; if1.req_we = '0; if1.req_addr = '0; if1.req_din = '0;
    if1.mon_we_b = 1'b0; if1.mon_addr_b = '0; if1.clr_collision = 1'b0;
    if3.req = '0; if3.req_we = '0; if3.req_addr = '0; if3.req_din = '0;
    if3.mon_we_b = 1'b0; if3.mon_addr_b = '0; if3.clr_collision = 1'b0;

    tick(); tick();
    chk("rst_gnt", 32'(if1.gnt), 32'h0);
    chk("rst_rvalid", 32'(if1.rvalid), 32'h0);
    chk("rst_rdata", 32'(if1.rdata), 32'h0);
    chk("rst_we", 32'(if1.ram_we_a), 32'h0);
    chk("rst_addr", 32'(if1.ram_addr_a), 32'h0);
    chk("rst_busy", 32'(if1.busy), 32'h0);
    chk("rst_coll", 32'(if1.collision), 32'h0);
    rst = 1'b0;
    tick();

    // single write
    if1.req = 4'b0001; if1.req_we = 4'b0001; if1.req_addr = 16'h0001; if1.req_din = 32'h0000_00A5;
    tick();
    chk("wr_gnt", 32'(if1.gnt), 32'h1);
    chk("wr_we", 32'(if1.ram_we_a), 32'h1);
    chk("wr_addr", 32'(if1.ram_addr_a), 32'h1);
    chk("wr_din", 32'(if1.ram_din_a), 32'hA5);
    chk("wr_busy", 32'(if1.busy), 32'h1);
    if1.req = '0;
    tick();
    chk("wr_gnt_drop", 32'(if1.gnt), 32'h0);
    chk("wr_we_drop", 32'(if1.ram_we_a), 32'h0);
    chk("wr_no_rvalid", 32'(if1.rvalid), 32'h0);
    chk("wr_idle", 32'(if1.busy), 32'h0);

    // read-back
    if1.req = 4'b0001; if1.req_we = 4'b0000;
    tick();
    chk("rd_gnt", 32'(if1.gnt), 32'h1);
    chk("rd_we", 32'(if1.ram_we_a), 32'h0);
    if1.req = '0;
    tick();
    chk("rd_rvalid_early", 32'(if1.rvalid), 32'h0);
    tick();
    chk("rd_rvalid", 32'(if1.rvalid), 32'h1);
    chk("rd_rdata", 32'(if1.rdata), 32'hA5);
    chk("rd_rid", 32'(if1.rid), 32'h0);
    tick();
    chk("rd_rvalid_pulse", 32'(if1.rvalid), 32'h0);

    // round robin from ptr=0
    rst = 1'b1; tick(); rst = 1'b0; tick();
    if1.req = 4'b1111; if1.req_we = 4'b0000; if1.req_addr = 16'h7654;
    for (int k = 0; k < 5; k++) begin
      tick();
      chk($sformatf("rr_gnt%0d", k), 32'(if1.gnt), 32'(4'b0001 << (k % 4)));
      if (k == 4) if1.req = '0;
      tick();
      chk($sformatf("rr_resp%0d", k), 32'(if1.rvalid), 32'h0);
      tick();
      chk($sformatf("rr_rvalid%0d", k), 32'(if1.rvalid), 32'h1);
      chk($sformatf("rr_rid%0d", k), 32'(if1.rid), 32'(k % 4));
      chk($sformatf("rr_rdata%0d", k), 32'(if1.rdata), 32'(8'h34 + 8'(k % 4)));
    end
    tick();
    chk("rr_no_extra_gnt", 32'(if1.gnt), 32'h0);

    // priority rotation: req0 was last, req1 wins
    if1.req = 4'b0011;
    tick();
    chk("rot_gnt1", 32'(if1.gnt), 32'h2);
    if1.req = 4'b0001;
    tick(); tick();
    chk("rot_rid1", 32'(if1.rid), 32'h1);
    chk("rot_rdata1", 32'(if1.rdata), 32'h35);
    tick();
    chk("rot_gnt0", 32'(if1.gnt), 32'h1);
    if1.req = '0;
    tick(); tick();
    chk("rot_rid0", 32'(if1.rid), 32'h0);
    chk("rot_rvalid0", 32'(if1.rvalid), 32'h1);
    tick();

    // collision, same address
    if1.req = 4'b0001; if1.req_we = 4'b0001; if1.req_addr = 16'h0002; if1.req_din = 32'h0000_005A;
    if1.mon_we_b = 1'b1; if1.mon_addr_b = 4'h2;
    tick();
    chk("col_gnt", 32'(if1.gnt), 32'h1);
    if1.req = '0;
    tick();
    chk("col_set", 32'(if1.collision), 32'h1);
    if1.mon_we_b = 1'b0;
    tick();
    chk("col_sticky", 32'(if1.collision), 32'h1);
    if1.clr_collision = 1'b1;
    tick();
    chk("col_clr", 32'(if1.collision), 32'h0);
    if1.clr_collision = 1'b0;

    // different address: no collision
    if1.req = 4'b0001; if1.mon_we_b = 1'b1; if1.mon_addr_b = 4'h3;
    tick();
    if1.req = '0;
    tick();
    chk("col_diff_addr", 32'(if1.collision), 32'h0);

    // set wins over simultaneous clear
    if1.req = 4'b0010; if1.req_we = 4'b0010; if1.req_addr = 16'h0020;
    if1.mon_addr_b = 4'h2;
    tick();
    chk("col2_gnt", 32'(if1.gnt), 32'h2);
    if1.req = '0; if1.clr_collision = 1'b1;
    tick();
    chk("col_set_wins", 32'(if1.collision), 32'h1);
    if1.mon_we_b = 1'b0;
    tick();
    chk("col_clr2", 32'(if1.collision), 32'h0);
    if1.clr_collision = 1'b0;

    // reset mid-read on u3 while u1 is writing
    if3.req = 4'b0001; if3.req_we = 4'b0000; if3.req_addr = 16'h0004;
    tick();
    chk("mid_gnt", 32'(if3.gnt), 32'h1);
    if3.req = '0;
    if1.req = 4'b0001; if1.req_we = 4'b0001; if1.req_addr = 16'h0009;
    tick();
    chk("mid_wait_busy", 32'(if3.busy), 32'h1);
    chk("mid_wait_addr", 32'(if3.ram_addr_a), 32'h4);
    chk("mid_u1_we", 32'(if1.ram_we_a), 32'h1);
    if1.req = '0;
    rst = 1'b1;
    #1;
    chk("mid_busy0", 32'(if3.busy), 32'h0);
    chk("mid_addr0", 32'(if3.ram_addr_a), 32'h0);
    chk("mid_gnt0", 32'(if3.gnt), 32'h0);
    chk("mid_u1_we0", 32'(if1.ram_we_a), 32'h0);
    tick(); tick();
    rst = 1'b0;
    for (int k = 0; k < 4; k++) begin
      tick();
      chk($sformatf("mid_no_rvalid%0d", k), 32'(if3.rvalid), 32'h0);
    end

    // after release: ptr back at 0, RD_LAT=3 read
    if3.req = 4'b0100; if3.req_addr = 16'h0600;
    tick();
    chk("post_gnt", 32'(if3.gnt), 32'h4);
    if3.req = '0;
    tick(); tick(); tick();
    chk("post_resp_no_rvalid", 32'(if3.rvalid), 32'h0);
    tick();
    chk("post_rvalid", 32'(if3.rvalid), 32'h1);
    chk("post_rid", 32'(if3.rid), 32'h2);
    chk("post_rdata", 32'(if3.rdata), 32'h36);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
